// File: rtl/stage_if.sv
// rtl/stage_if.sv - RISC-V instruction-fetch stage: PC, req/ack fetch, one-word stall buffer, IF/ID register
module stage_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br,
   input  logic [31:0] br_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'h3;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;

   logic        req_int;
   logic        redirect;
   logic        accept;
   logic [31:0] br_tgt;

   // While a dropped fetch is in flight pc_q keeps its address; the redirect target waits in tgt_q.
   assign req_int  = (state_q != S_IDLE) || !buf_valid_q;
   assign mem_req  = rst_n & req_int;
   assign mem_addr = pc_q & ~32'h3;
   assign redirect = br & ~stall;
   assign accept   = req_int & mem_ack & (state_q != S_DROP) & ~redirect;
   assign br_tgt   = br_addr & ~32'h3;

   assign id_pc    = id_pc_q;
   assign id_inst  = id_inst_q;
   assign id_valid = id_valid_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      buf_valid_d = buf_valid_q;
      buf_pc_d    = buf_pc_q;
      buf_inst_d  = buf_inst_q;
      id_pc_d     = id_pc_q;
      id_inst_d   = id_inst_q;
      id_valid_d  = id_valid_q;

      if (redirect) begin
         buf_valid_d = 1'b0;
         id_valid_d  = 1'b0;
         id_inst_d   = NOP_INST;
         if (req_int && !mem_ack) begin
            state_d = S_DROP;
            tgt_d   = br_tgt;
         end else begin
            state_d = S_IDLE;
            pc_d    = br_tgt;
         end
      end else begin
         case (state_q)
            S_IDLE:  if (req_int && !mem_ack) state_d = S_WAIT;
            S_WAIT:  if (mem_ack) state_d = S_IDLE;
            S_DROP:  if (mem_ack) begin
                        state_d = S_IDLE;
                        pc_d    = tgt_q;
                     end
            default: state_d = S_IDLE;
         endcase

         if (accept) begin
            pc_d = pc_q + 32'd4;
            if (stall) begin
               buf_valid_d = 1'b1;
               buf_pc_d    = pc_q;
               buf_inst_d  = mem_rdata;
            end else begin
               id_pc_d    = pc_q;
               id_inst_d  = mem_rdata;
               id_valid_d = 1'b1;
            end
         end else if (!stall) begin
            if (buf_valid_q) begin
               buf_valid_d = 1'b0;
               id_pc_d     = buf_pc_q;
               id_inst_d   = buf_inst_q;
               id_valid_d  = 1'b1;
            end else begin
               id_inst_d  = NOP_INST;
               id_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC_A;
         tgt_q       <= RESET_PC_A;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= 32'd0;
         buf_inst_q  <= NOP_INST;
         id_pc_q     <= 32'd0;
         id_inst_q   <= NOP_INST;
         id_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         tgt_q       <= tgt_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_inst_q  <= buf_inst_d;
         id_pc_q     <= id_pc_d;
         id_inst_q   <= id_inst_d;
         id_valid_q  <= id_valid_d;
      end
   end

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - bench for stage_if: directed vector table, random run against a stream model, reset and wrap cases
module tb_stage_if;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, stall, br, mem_req, mem_ack, id_valid;
   logic [31:0] br_addr, mem_addr, mem_rdata, id_pc, id_inst;

   int          lat;
   int          cnt;
   logic        rmode, rnd_ack;

   logic        pre_req, pre_ack;
   logic [31:0] pre_addr;

   int          n_tests, n_fail;

   // Memory: ack after lat waiting cycles, or randomly; data encodes the address.
   assign mem_ack   = mem_req && (rmode ? rnd_ack : (cnt >= lat));
   assign mem_rdata = 32'h0000_0093 | mem_addr;

   always @(posedge clk) begin
      if (!rst_n)                  cnt <= 0;
      else if (mem_req && mem_ack) cnt <= 0;
      else if (mem_req)            cnt <= cnt + 1;
      else                         cnt <= 0;
   end

   stage_if u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .br(br), .br_addr(br_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
   );

   logic        rst2_n, w_req, w_valid, w_ack;
   logic [31:0] w_addr, w_rdata, w_pc, w_inst;
   assign w_ack   = 1'b1;
   assign w_rdata = 32'h0000_0093 | w_addr;

   stage_if #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
      .clk(clk), .rst_n(rst2_n), .stall(1'b0), .br(1'b0), .br_addr(32'd0),
      .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
      .id_pc(w_pc), .id_inst(w_inst), .id_valid(w_valid)
   );

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] br_addr;
      int          lat;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic s, input logic b, input logic [31:0] a, input int l,
                       input logic r, input logic [31:0] ad, input logic v, input logic [31:0] p);
      vecs.push_back('{s, b, a, l, r, ad, v, p});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic b, input logic [31:0] a);
      stall   = s;
      br      = b;
      br_addr = a;
      rnd_ack = ($urandom_range(2) != 0);
      #2;
      pre_req  = mem_req;
      pre_ack  = mem_ack;
      pre_addr = mem_addr;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_pc, m_pc, m_inst, ra;
   logic        m_valid, rs, rb;
   int          delivered;

   initial begin
      n_tests = 0; n_fail = 0; delivered = 0;
      rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; br = 1'b0; br_addr = 32'd0;
      lat = 0; rmode = 1'b0; rnd_ack = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req",  32'(mem_req), 32'd0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_inst",  id_inst, NOP);
      chk("rst_id_pc",    id_pc, 32'd0);
      chk("wrap_rst_req", 32'(w_req), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("first_req",  32'(mem_req), 32'd1);
      chk("first_addr", mem_addr, 32'd0);

      //   stall br  br_addr      lat  req  mem_addr       valid id_pc
      addv(0, 0, 32'h0,   0, 1, 32'h004, 1, 32'h000);
      addv(0, 0, 32'h0,   0, 1, 32'h008, 1, 32'h004);
      addv(0, 0, 32'h0,   0, 1, 32'h00C, 1, 32'h008);
      addv(0, 0, 32'h0,   3, 1, 32'h00C, 0, 32'h008);
      addv(0, 0, 32'h0,   3, 1, 32'h00C, 0, 32'h008);
      addv(0, 0, 32'h0,   3, 1, 32'h00C, 0, 32'h008);
      addv(0, 0, 32'h0,   3, 1, 32'h010, 1, 32'h00C);
      addv(1, 0, 32'h0,   3, 1, 32'h010, 1, 32'h00C);
      addv(1, 0, 32'h0,   3, 1, 32'h010, 1, 32'h00C);
      addv(1, 0, 32'h0,   3, 1, 32'h010, 1, 32'h00C);
      addv(1, 0, 32'h0,   3, 0, 32'h014, 1, 32'h00C);
      addv(1, 0, 32'h0,   3, 0, 32'h014, 1, 32'h00C);
      addv(0, 0, 32'h0,   3, 1, 32'h014, 1, 32'h010);
      addv(0, 0, 32'h0,   3, 1, 32'h014, 0, 32'h010);
      addv(0, 1, 32'h100, 3, 1, 32'h014, 0, 32'h010);
      addv(0, 0, 32'h0,   3, 1, 32'h014, 0, 32'h010);
      addv(0, 0, 32'h0,   3, 1, 32'h100, 0, 32'h010);
      addv(0, 0, 32'h0,   3, 1, 32'h100, 0, 32'h010);
      addv(0, 0, 32'h0,   3, 1, 32'h100, 0, 32'h010);
      addv(0, 0, 32'h0,   3, 1, 32'h100, 0, 32'h010);
      addv(0, 0, 32'h0,   3, 1, 32'h104, 1, 32'h100);
      addv(0, 0, 32'h0,   0, 1, 32'h108, 1, 32'h104);
      addv(1, 1, 32'h200, 0, 0, 32'h10C, 1, 32'h104);
      addv(1, 1, 32'h200, 0, 0, 32'h10C, 1, 32'h104);
      addv(0, 1, 32'h102, 0, 1, 32'h100, 0, 32'h104);
      addv(0, 0, 32'h0,   0, 1, 32'h104, 1, 32'h100);
      addv(0, 1, 32'h040, 0, 1, 32'h040, 0, 32'h100);
      addv(0, 0, 32'h0,   0, 1, 32'h044, 1, 32'h040);

      foreach (vecs[i]) begin
         lat = vecs[i].lat;
         step(vecs[i].stall, vecs[i].br, vecs[i].br_addr);
         chk($sformatf("vec%0d_mem_req", i),  32'(mem_req), 32'(vecs[i].e_req));
         chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d_id_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_id_pc", i),    id_pc, vecs[i].e_pc);
         chk($sformatf("vec%0d_id_inst", i),  id_inst,
             vecs[i].e_valid ? (32'h93 | vecs[i].e_pc) : NOP);
      end

      // Stream model: delivered words follow program order from the last redirect target.
      rmode   = 1'b1;
      m_valid = 1'b1; m_pc = 32'h40; m_inst = 32'hD3; exp_pc = 32'h44;
      for (int c = 0; c < 1500; c++) begin
         rs = ($urandom_range(3) == 0);
         rb = ($urandom_range(9) == 0);
         ra = $urandom;
         step(rs, rb, ra);
         if (pre_req && !pre_ack && mem_req)
            chk("rnd_addr_stable", mem_addr, pre_addr);
         if (rs) begin
            chk("rnd_stall_valid", 32'(id_valid), 32'(m_valid));
            chk("rnd_stall_pc", id_pc, m_pc);
            chk("rnd_stall_inst", id_inst, m_inst);
         end else if (rb) begin
            chk("rnd_br_valid", 32'(id_valid), 32'd0);
            chk("rnd_br_pc", id_pc, m_pc);
            chk("rnd_br_inst", id_inst, NOP);
            m_valid = 1'b0; m_inst = NOP;
            exp_pc = ra & ~32'h3;
         end else if (id_valid) begin
            chk("rnd_pc", id_pc, exp_pc);
            chk("rnd_inst", id_inst, 32'h93 | exp_pc);
            m_valid = 1'b1; m_pc = exp_pc; m_inst = 32'h93 | exp_pc;
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end else begin
            chk("rnd_bubble_pc", id_pc, m_pc);
            chk("rnd_bubble_inst", id_inst, NOP);
            m_valid = 1'b0; m_inst = NOP;
         end
      end
      chk("rnd_progress", 32'(delivered > 200), 32'd1);
      rmode = 1'b0;

      // Asynchronous reset while a fetch is waiting.
      stall = 1'b0; br = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1; lat = 0;
      step(0, 0, 32'd0);
      chk("rr_id_pc0", id_pc, 32'h0);
      step(0, 0, 32'd0);
      chk("rr_id_pc4", id_pc, 32'h4);
      lat = 3;
      step(1, 0, 32'd0);
      chk("rr_wait_req",   32'(mem_req), 32'd1);
      chk("rr_wait_addr",  mem_addr, 32'h8);
      chk("rr_wait_valid", 32'(id_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rr_async_req",   32'(mem_req), 32'd0);
      chk("rr_async_valid", 32'(id_valid), 32'd0);
      chk("rr_async_inst",  id_inst, NOP);
      chk("rr_async_pc",    id_pc, 32'd0);
      stall = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1; lat = 0;
      #1;
      chk("rr_restart_req",  32'(mem_req), 32'd1);
      chk("rr_restart_addr", mem_addr, 32'd0);
      step(0, 0, 32'd0);
      chk("rr_restart_pc",    id_pc, 32'd0);
      chk("rr_restart_valid", 32'(id_valid), 32'd1);

      // PC wrap from a top-of-memory reset vector.
      rst2_n = 1'b1;
      #1;
      chk("wrap_req",   32'(w_req), 32'd1);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      @(posedge clk);
      #1;
      chk("wrap_addr1", w_addr, 32'h0);
      chk("wrap_pc1",   w_pc, 32'hFFFF_FFFC);
      chk("wrap_inst1", w_inst, 32'hFFFF_FFFF);
      chk("wrap_val1",  32'(w_valid), 32'd1);
      @(posedge clk);
      #1;
      chk("wrap_addr2", w_addr, 32'h4);
      chk("wrap_pc2",   w_pc, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
